pixel_readout: RTL and testbench
================================

# pixel_readout

Receiving end of the pixel state machine's control interface. Follows the erase/expose/convert/read strobes and row/column addresses and drives the shared ADC ramp counter to the pixel array during convert. During read it captures each addressed pixel's stored code, tags it with its address and queues it in a small first-word-fall-through FIFO with a valid/ready output for downstream frame storage.

## Interface

Parameters:
- num_pixels, 64, pixels per frame; perfect square, power of 4
- data_width, 8, ADC code width
- fifo_depth, 4, output FIFO entries; power of 2, ≥2

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- erase  input  1  erase phase strobe from the pixel state machine
- expose  input  1  expose phase strobe
- convert  input  1  convert phase strobe
- read  input  1  read phase strobe; one pixel per cycle
- row_addr  input  AW=$clog2(sqrt(num_pixels))  row of the pixel being read
- col_addr  input  AW  column of the pixel being read
- ramp_cnt  output  data_width  ADC ramp code broadcast to all pixels
- pix_data  input  data_width  code of the addressed pixel; combinational from row_addr/col_addr
- out_data  output  data_width  queued pixel code (binary)
- out_addr  output  2*AW  queued pixel address {row, col}
- out_valid  output  1  FIFO head valid
- out_ready  input  1  downstream accepts the head
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is queued
- overflow  output  1  sticky; a read sample was dropped

## Operation

- Phase tracking FSM: IDLE, ERASE, EXPOSE, CONVERT, READ. The next state is decided on each edge from the strobes, with priority erase > expose > convert > read. With no strobe high, the FSM goes to IDLE. Multiple strobes high at once resolve by this priority.
- Entering ERASE clears overflow, the pixel counter and ramp_cnt. The FIFO is not flushed.
- CONVERT: ramp_cnt is 0 on the first CONVERT cycle and increments by 1 each following cycle. It saturates at 2^data_width−1 and does not wrap. Leaving CONVERT holds the value until the next ERASE or the next CONVERT entry, which reloads 0.
- READ: on every edge with read high, {row_addr, col_addr} and pix_data are sampled.
  - If the FIFO is not full, or a pop occurs on the same edge, the sample is pushed.
  - Otherwise the sample is dropped and overflow is set.
  - In both cases the pixel counter increments.
- The pixel counter is $clog2(num_pixels)+1 bits. When it reaches num_pixels, frame_done pulses for one cycle and the counter returns to 0.
- If read deasserts before num_pixels samples, there is no frame_done. The count is kept until ERASE.
- Pop: out_valid && out_ready on an edge removes the head.
- Simultaneous push and pop are always allowed, including when the FIFO is full or empty.
- Pushing to an empty FIFO while out_ready is high still takes one cycle. There is no bypass.

## Timing

- Reset values: ramp_cnt=0, out_data=0, out_addr=0, out_valid=0, frame_done=0, overflow=0. The FSM is in IDLE and the FIFO is empty.
- Strobes and addresses change on clock edges. pix_data must settle within the same cycle.
- ramp_cnt is registered. The value k is visible during the (k+1)th CONVERT cycle.
- Capture latency: a sample taken at edge n is on out_data/out_addr with out_valid=1 after edge n, if the FIFO was empty.
- frame_done is high in the cycle after the edge that sampled the last pixel.
- overflow is set after the dropping edge and holds until ERASE or reset.
- reset_n low at any time forces all reset values asynchronously. Queued data is lost.

## Configuration

- PIXEL_READOUT_GRAY_EN defined:
  - ramp_cnt is driven as the Gray code of the internal binary ramp.
  - pix_data is treated as Gray and converted to binary before being pushed.
  - out_data is always binary.
  - Saturation applies to the binary ramp, so the held output is Gray(2^data_width−1).
- PIXEL_READOUT_GRAY_EN undefined: ramp_cnt and pix_data are plain binary, with no conversion.

## Test plan

- Reset then 10 CONVERT cycles -> ramp_cnt steps 0..9. With data_width=4 and 20 CONVERT cycles -> ramp_cnt holds 15.
- READ of 64 pixels with pix_data = addr ^ 8'hA5, out_ready=1 -> 64 pops in order, out_addr 0..63, matching data, one frame_done pulse, overflow=0.
- out_ready=0 during a 6-pixel read with fifo_depth=4 -> 4 entries kept (addr 0..3), overflow=1. A following ERASE clears overflow.
- FIFO full with simultaneous push and pop -> push accepted, occupancy stays 4, no overflow.
- reset_n pulsed low mid-READ after 10 pixels -> out_valid=0 immediately. The next full 64-pixel READ produces exactly one frame_done.
- With PIXEL_READOUT_GRAY_EN: ramp_cnt sequence 0,1,3,2,6. pix_data=8'h0C (Gray) -> out_data=8'h08.

Source files
------------

// File: rtl/pixel_readout.sv
// Receive side of the pixel state machine: tracks erase/expose/convert/read phases, drives the ADC ramp
// and queues tagged pixel samples in a FWFT FIFO. Optional macro PIXEL_READOUT_GRAY_EN selects Gray-coded ramp/pixel codes.
module pixel_readout #(
    parameter int num_pixels = 64,
    parameter int data_width = 8,
    parameter int fifo_depth = 4
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  erase,
    input  logic                                  expose,
    input  logic                                  convert,
    input  logic                                  read,
    input  logic [$clog2(num_pixels)/2-1:0]       row_addr,
    input  logic [$clog2(num_pixels)/2-1:0]       col_addr,
    output logic [data_width-1:0]                 ramp_cnt,
    input  logic [data_width-1:0]                 pix_data,
    output logic [data_width-1:0]                 out_data,
    output logic [2*($clog2(num_pixels)/2)-1:0]   out_addr,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  frame_done,
    output logic                                  overflow
);

    localparam int AW = $clog2(num_pixels) / 2;
    localparam int CW = $clog2(num_pixels) + 1;
    localparam int PW = $clog2(fifo_depth);

    localparam logic [data_width-1:0] RAMP_ZERO = {data_width{1'b0}};
    localparam logic [data_width-1:0] RAMP_ONE  = {{(data_width-1){1'b0}}, 1'b1};
    localparam logic [data_width-1:0] RAMP_MAX  = {data_width{1'b1}};
    localparam logic [CW-1:0]         CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]         CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]         CNT_FRAME = CW'(num_pixels);
    localparam logic [PW-1:0]         PTR_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0]         PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]           OCC_ZERO  = {(PW+1){1'b0}};
    localparam logic [PW:0]           OCC_ONE   = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]           OCC_FULL  = (PW+1)'(fifo_depth);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4
    } state_t;

`ifdef PIXEL_READOUT_GRAY_EN
    function automatic logic [data_width-1:0] bin_to_gray(input logic [data_width-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [data_width-1:0] gray_to_bin(input logic [data_width-1:0] g);
        logic [data_width-1:0] b;
        b[data_width-1] = g[data_width-1];
        for (int i = data_width - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
`endif

    state_t                  state_r, next_state_s;
    logic [data_width-1:0]   ramp_bin_r, ramp_next_s, ramp_cnt_r, ramp_out_s;
    logic [CW-1:0]           pix_cnt_r, pix_cnt_next_s, pix_cnt_inc_s;
    logic                    frame_done_r, frame_next_s;
    logic                    overflow_r, overflow_next_s;
    logic                    clear_s, sample_s, push_s, pop_s, full_s;
    logic [data_width-1:0]   push_data_s;
    logic [data_width-1:0]   mem_data_r [fifo_depth];
    logic [2*AW-1:0]         mem_addr_r [fifo_depth];
    logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [PW:0]             occ_r, occ_next_s;
    logic                    out_valid_r;

    // Strobe priority: erase > expose > convert > read, otherwise idle
    always_comb begin
        next_state_s = ST_IDLE;
        if (erase) begin
            next_state_s = ST_ERASE;
        end else if (expose) begin
            next_state_s = ST_EXPOSE;
        end else if (convert) begin
            next_state_s = ST_CONVERT;
        end else if (read) begin
            next_state_s = ST_READ;
        end else begin
            next_state_s = ST_IDLE;
        end
    end

    // Phase actions, ramp/counter/FIFO next values derived from the winning strobe
    always_comb begin
        clear_s     = 1'b0;
        sample_s    = 1'b0;
        ramp_next_s = ramp_bin_r;
        case (next_state_s)
            ST_ERASE: begin
                clear_s     = 1'b1;
                ramp_next_s = RAMP_ZERO;
            end
            ST_CONVERT: begin
                if (state_r != ST_CONVERT) begin
                    ramp_next_s = RAMP_ZERO;
                end else if (ramp_bin_r != RAMP_MAX) begin
                    ramp_next_s = ramp_bin_r + RAMP_ONE;
                end else begin
                    ramp_next_s = ramp_bin_r;
                end
            end
            ST_READ:  sample_s = 1'b1;
            default:  sample_s = 1'b0;
        endcase

`ifdef PIXEL_READOUT_GRAY_EN
        ramp_out_s  = bin_to_gray(ramp_next_s);
        push_data_s = gray_to_bin(pix_data);
`else
        ramp_out_s  = ramp_next_s;
        push_data_s = pix_data;
`endif

        full_s = (occ_r == OCC_FULL);
        pop_s  = out_valid_r && out_ready;
        // A full FIFO still accepts a sample when its head leaves on the same edge
        push_s = sample_s && (!full_s || pop_s);

        pix_cnt_inc_s  = pix_cnt_r + CNT_ONE;
        pix_cnt_next_s = pix_cnt_r;
        frame_next_s   = 1'b0;
        if (clear_s) begin
            pix_cnt_next_s = CNT_ZERO;
        end else if (sample_s) begin
            if (pix_cnt_inc_s == CNT_FRAME) begin
                pix_cnt_next_s = CNT_ZERO;
                frame_next_s   = 1'b1;
            end else begin
                pix_cnt_next_s = pix_cnt_inc_s;
            end
        end else begin
            pix_cnt_next_s = pix_cnt_r;
        end

        if (clear_s) begin
            overflow_next_s = 1'b0;
        end else if (sample_s && !push_s) begin
            overflow_next_s = 1'b1;
        end else begin
            overflow_next_s = overflow_r;
        end

        case ({push_s, pop_s})
            2'b10:   occ_next_s = occ_r + OCC_ONE;
            2'b01:   occ_next_s = occ_r - OCC_ONE;
            default: occ_next_s = occ_r;
        endcase
    end

    // Phase state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Ramp, pixel counter and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ramp_bin_r   <= RAMP_ZERO;
            ramp_cnt_r   <= RAMP_ZERO;
            pix_cnt_r    <= CNT_ZERO;
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            ramp_bin_r   <= ramp_next_s;
            ramp_cnt_r   <= ramp_out_s;
            pix_cnt_r    <= pix_cnt_next_s;
            frame_done_r <= frame_next_s;
            overflow_r   <= overflow_next_s;
        end
    end

    // Output FIFO storage and pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < fifo_depth; i++) begin
                mem_data_r[i] <= RAMP_ZERO;
                mem_addr_r[i] <= {(2*AW){1'b0}};
            end
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            occ_r       <= OCC_ZERO;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= push_data_s;
                mem_addr_r[wr_ptr_r] <= {row_addr, col_addr};
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            occ_r       <= occ_next_s;
            out_valid_r <= (occ_next_s != OCC_ZERO);
        end
    end

    assign ramp_cnt   = ramp_cnt_r;
    assign out_data   = mem_data_r[rd_ptr_r];
    assign out_addr   = mem_addr_r[rd_ptr_r];
    assign out_valid  = out_valid_r;
    assign frame_done = frame_done_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_pixel_readout.sv
// Bench for pixel_readout: queue-based reference model checked every cycle, directed phase scenarios, random phases.
`timescale 1ns/1ps
module tb_pixel_readout;
    localparam int NP    = 64;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int MAXR  = (1 << DW) - 1;

    logic clk = 1'b0, reset_n = 1'b0;
    logic erase = 1'b0, expose = 1'b0, convert = 1'b0, read = 1'b0, out_ready = 1'b0;
    logic [AW-1:0]   row_addr = '0, col_addr = '0;
    logic [DW-1:0]   ramp_cnt, pix_data, out_data;
    logic [2*AW-1:0] out_addr;
    logic            out_valid, frame_done, overflow;
    logic [DW-1:0]   pix_mem [NP];

    int n_checks = 0, n_fail = 0;
    int pops = 0, fd_cnt = 0, last_pop_addr = -1;

    typedef struct packed {
        logic [DW-1:0]   d;
        logic [2*AW-1:0] a;
    } ent_t;
    ent_t q[$];
    ent_t m_e;
    int   m_ramp = 0, m_cnt = 0, m_prev = 0, m_win = 0;
    bit   m_ovf = 0, m_fd = 0, m_pop = 0;

    assign pix_data = pix_mem[{row_addr, col_addr}];

    pixel_readout #(.num_pixels(NP), .data_width(DW), .fifo_depth(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .erase(erase), .expose(expose), .convert(convert),
        .read(read), .row_addr(row_addr), .col_addr(col_addr), .ramp_cnt(ramp_cnt),
        .pix_data(pix_data), .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic int m_gray(input int b);
        return (b ^ (b >> 1)) & MAXR;
    endfunction

    function automatic int m_ungray(input int g);
        int b = 0;
        for (int i = 0; i < DW; i++) b ^= (g >> i);
        return b & MAXR;
    endfunction

    function automatic int exp_ramp();
`ifdef PIXEL_READOUT_GRAY_EN
        return m_gray(m_ramp);
`else
        return m_ramp;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per active edge, cleared by reset
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            q.delete(); m_ramp = 0; m_cnt = 0; m_ovf = 0; m_fd = 0; m_prev = 0;
        end else begin
            m_win = erase ? 1 : expose ? 2 : convert ? 3 : read ? 4 : 0;
            m_fd  = 0;
            m_pop = (q.size() != 0) && out_ready;
            if (m_win == 1) begin m_ramp = 0; m_ovf = 0; m_cnt = 0; end
            if (m_win == 3) m_ramp = (m_prev == 3) ? ((m_ramp < MAXR) ? m_ramp + 1 : MAXR) : 0;
            if (m_pop) void'(q.pop_front());
            if (m_win == 4) begin
`ifdef PIXEL_READOUT_GRAY_EN
                m_e.d = DW'(m_ungray(int'(pix_data)));
`else
                m_e.d = pix_data;
`endif
                m_e.a = {row_addr, col_addr};
                if ((q.size() + (m_pop ? 1 : 0)) < DEPTH || m_pop) q.push_back(m_e);
                else m_ovf = 1;
                m_cnt++;
                if (m_cnt == NP) begin m_fd = 1; m_cnt = 0; end
            end
            m_prev = m_win;
        end
    end

    // Compare DUT against the model on every falling edge
    initial forever begin
        @(negedge clk);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("out_data", out_data, q[0].d);
            check("out_addr", out_addr, q[0].a);
        end
        check("ramp_cnt", ramp_cnt, exp_ramp());
        check("overflow", overflow, m_ovf);
        check("frame_done", frame_done, m_fd);
        if (out_valid && out_ready) begin pops++; last_pop_addr = out_addr; end
        if (frame_done) fd_cnt++;
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic strobes(input logic e, input logic x, input logic c, input logic r);
        erase = e; expose = x; convert = c; read = r;
    endtask

    task automatic read_px(input int a);
        strobes(1'b0, 1'b0, 1'b0, 1'b1);
        {row_addr, col_addr} = 6'(a);
        cyc();
    endtask

    task automatic do_erase();
        strobes(1'b1, 1'b0, 1'b0, 1'b0); cyc();
        strobes(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int bp, bf, ramp_exp;
    initial begin
        for (int a = 0; a < NP; a++) pix_mem[a] = DW'(a) ^ 8'hA5;
        repeat (2) cyc();
        check("rst_ramp", ramp_cnt, 0); check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0); check("rst_addr", out_addr, 0);
        check("rst_ovf", overflow, 0);  check("rst_fd", frame_done, 0);
        reset_n = 1'b1; cyc();

        // Ramp: 0,1,2.. (binary) or 0,1,3,2,6.. (Gray), then saturation and hold
        strobes(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc();
`ifdef PIXEL_READOUT_GRAY_EN
        ramp_exp = 3;
`else
        ramp_exp = 2;
`endif
        check("ramp_3rd", ramp_cnt, ramp_exp);
        repeat (2) cyc();
`ifdef PIXEL_READOUT_GRAY_EN
        ramp_exp = 6;
`else
        ramp_exp = 4;
`endif
        check("ramp_5th", ramp_cnt, ramp_exp);
        repeat (5) cyc();
`ifdef PIXEL_READOUT_GRAY_EN
        ramp_exp = 8'h0D;
`else
        ramp_exp = 9;
`endif
        check("ramp_10th", ramp_cnt, ramp_exp);
        repeat (290) cyc();
`ifdef PIXEL_READOUT_GRAY_EN
        ramp_exp = 8'h80;
`else
        ramp_exp = 8'hFF;
`endif
        check("ramp_sat", ramp_cnt, ramp_exp);
        strobes(1'b0, 1'b0, 1'b0, 1'b0); repeat (3) cyc();
        check("ramp_hold", ramp_cnt, ramp_exp);
        do_erase(); check("ramp_erase", ramp_cnt, 0);

        // Full frame with ready high
        out_ready = 1'b1; bp = pops; bf = fd_cnt;
        for (int a = 0; a < NP; a++) read_px(a);
        strobes(1'b0, 1'b0, 1'b0, 1'b0); repeat (6) cyc();
        check("frame_pops", pops - bp, 64); check("frame_fd", fd_cnt - bf, 1);
        check("frame_last", last_pop_addr, 63); check("frame_ovf", overflow, 0);

        // Backpressure: 6 reads into 4 entries
        do_erase(); out_ready = 1'b0; bp = pops;
        for (int a = 0; a < 6; a++) read_px(a);
        strobes(1'b0, 1'b0, 1'b0, 1'b0); repeat (2) cyc();
        check("bp_ovf", overflow, 1); check("bp_valid", out_valid, 1); check("bp_head", out_addr, 0);
        out_ready = 1'b1; repeat (6) cyc();
        check("bp_pops", pops - bp, 4); check("bp_last", last_pop_addr, 3);
        do_erase(); check("bp_clear", overflow, 0);

        // Full FIFO, simultaneous push and pop
        do_erase(); out_ready = 1'b0;
        for (int a = 0; a < 4; a++) read_px(a);
        out_ready = 1'b1; read_px(4);
        check("full_pp_ovf", overflow, 0); check("full_pp_head", out_addr, 1);
        strobes(1'b0, 1'b0, 1'b0, 1'b0); repeat (6) cyc();

        // Asynchronous reset in the middle of a read
        do_erase(); out_ready = 1'b1;
        for (int a = 0; a < 10; a++) read_px(a);
        {row_addr, col_addr} = 6'd10; #3;
        reset_n = 1'b0; #1;
        check("mid_rst_valid", out_valid, 0);
        strobes(1'b0, 1'b0, 1'b0, 1'b0); cyc();
        reset_n = 1'b1; cyc();
        bf = fd_cnt;
        for (int a = 0; a < NP; a++) read_px(a);
        strobes(1'b0, 1'b0, 1'b0, 1'b0); repeat (6) cyc();
        check("post_rst_fd", fd_cnt - bf, 1);

        // Pixel code conversion
        do_erase(); pix_mem[0] = 8'h0C; read_px(0);
        strobes(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIXEL_READOUT_GRAY_EN
        check("pix_code", out_data, 8'h08);
`else
        check("pix_code", out_data, 8'h0C);
`endif
        repeat (2) cyc();

        // Random phases, strobe overlaps, addresses and backpressure
        for (int a = 0; a < NP; a++) pix_mem[a] = DW'($urandom);
        for (int blk = 0; blk < 250; blk++) begin
            int mode, len;
            mode = $urandom_range(0, 6);
            len  = $urandom_range(1, 20);
            case (mode)
                0:       strobes(1'b1, 1'b0, 1'b0, 1'b0);
                1:       strobes(1'b0, 1'b1, 1'b0, 1'b0);
                2:       strobes(1'b0, 1'b0, 1'b1, 1'b0);
                3, 4:    strobes(1'b0, 1'b0, 1'b0, 1'b1);
                5:       strobes(1'b0, 1'b0, 1'b0, 1'b0);
                default: strobes(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            endcase
            for (int c = 0; c < len; c++) begin
                row_addr  = AW'($urandom);
                col_addr  = AW'($urandom);
                out_ready = ($urandom_range(0, 9) < 7);
                cyc();
            end
        end
        strobes(1'b0, 1'b0, 1'b0, 1'b0); out_ready = 1'b1; repeat (8) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
